counter_8bit_monitor: RTL and testbench
=======================================

// Module: counter_8bit_monitor
// PURPOSE
//   Passive checker on the count output of an 8-bit enabled up-counter (ports count_enb/count).
//   Samples count_enb and count on every clk edge and predicts the next count value.
//   Flags mismatches and tracks wrap-arounds (0xFF->0x00).
//   Sits beside the counter in simulation and FPGA self-test builds; it never drives the counter.
// PARAMETERS
//   WIDTH        8   width of the monitored count bus
//   CNT_W        16  width of err_count and wrap_count (both saturate)
//   LOCK_CYCLES  4   consecutive good predictions required before locked asserts (1..15)
// PORTS
//   clk         in   1        system clock, all logic on posedge
//   reset       in   1        synchronous, active-low reset
//   count_enb   in   1        enable seen by the monitored counter
//   count       in   WIDTH    monitored counter output
//   locked      out  1        monitor has verified LOCK_CYCLES consecutive transitions
//   err_pulse   out  1        one-cycle pulse per mismatch detected while locked
//   err_count   out  CNT_W    total mismatches while locked, saturating at all-ones
//   wrap_pulse  out  1        one-cycle pulse per verified 0xFF->0x00 wrap
//   wrap_count  out  CNT_W    total verified wraps, saturating at all-ones
//   last_bad    out  WIDTH    count value observed at the most recent mismatch
// BEHAVIOUR
//   Reset (reset==0 at posedge):
//     - state=IDLE; locked=0, err_pulse=0, wrap_pulse=0, err_count=0, wrap_count=0, last_bad=0
//     - internal prev_count=0, prev_enb=0, good_cnt=0
//     - Reset mid-run discards all history; no error is raised across reset.
//   Sampling: every posedge outside reset captures prev_count<=count, prev_enb<=count_enb.
//   Prediction at each edge:
//     - exp = prev_enb ? prev_count+1 (mod 2^WIDTH) : prev_count
//     - match = (count==exp)
//   FSM:
//     - IDLE: first edge after reset only loads prev_*; goes to ACQUIRE with good_cnt=0.
//     - ACQUIRE: on match, good_cnt++. When good_cnt reaches LOCK_CYCLES, go to LOCKED and set locked=1.
//       On mismatch, good_cnt=0 and stay in ACQUIRE; no err_pulse, counters unchanged.
//     - LOCKED: on match, stay. On mismatch: err_pulse=1 for exactly one cycle,
//       err_count++ (saturating), last_bad<=count, locked=0, good_cnt=0, go to ACQUIRE.
//   Wrap detection:
//     - Condition: state LOCKED, prev_enb=1, prev_count=all-ones, count=0.
//     - Effect: wrap_pulse=1 for one cycle, wrap_count++ (saturating).
//     - A wrap on a mismatching edge is not possible (exp=0 there), so the two pulses are mutually exclusive.
//   Latency: all outputs are registered. A mismatch on count sampled at edge k shows
//     err_pulse/last_bad high/updated after edge k, low again after edge k+1 unless a new mismatch occurs.
//   Hold: count_enb=0 with count steady is a match (hold is legal).
//     count_enb=0 with count changing is a mismatch.
//   Saturation: err_count/wrap_count stop at 2^CNT_W-1; the pulses still fire.
// TESTING
//   1. Reset, count_enb=1, count increments 0,1,2,... -> locked=1 after 1+LOCK_CYCLES edges;
//      err_count=0; wrap_pulse at 0xFF->0x00; wrap_count=1 after 256 steps.
//   2. Locked, count_enb=0 for 8 cycles, count holds 0x37 -> locked stays 1, no err_pulse.
//   3. Locked at 0x10 with enable=1, force count=0x20 instead of 0x11 -> err_pulse one cycle,
//      err_count=1, last_bad=0x20, locked=0; relocks after LOCK_CYCLES good steps from 0x20.
//   4. Locked, count_enb=0 but count steps 0x40->0x41 -> err_pulse, last_bad=0x41.
//   5. reset low mid-run for 1 cycle, with count jumping arbitrarily around it -> all outputs 0,
//      no err_pulse; relocks normally.
//   6. CNT_W=2, inject 5 mismatches while locked -> err_count saturates at 3; 5 err_pulses seen.

Source files
------------

// File: rtl/counter_8bit_monitor.sv
// counter_8bit_monitor: passive checker predicting an enabled up-counter's next value, flagging mismatches and wraps
module counter_8bit_monitor #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 16,
    parameter int LOCK_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_enb,
    input  logic [WIDTH-1:0] count,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0] last_bad
);
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    state_t           state;
    logic [WIDTH-1:0] prev_count;
    logic             prev_enb;
    logic [3:0]       good_cnt;
    logic [WIDTH-1:0] exp_count;
    logic             match;
    logic             wrap;

    always_comb begin
        exp_count = prev_enb ? prev_count + 1'b1 : prev_count;
        match     = count == exp_count;
        wrap      = state == LOCKED && prev_enb && &prev_count && count == '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            prev_count <= '0;
            prev_enb   <= 1'b0;
            good_cnt   <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            last_bad   <= '0;
        end else begin
            prev_count <= count;
            prev_enb   <= count_enb;
            err_pulse  <= 1'b0;
            wrap_pulse <= wrap;
            if (wrap)
                wrap_count <= &wrap_count ? wrap_count : wrap_count + 1'b1;
            case (state)
                IDLE: begin
                    state    <= ACQUIRE;
                    good_cnt <= '0;
                end
                ACQUIRE: begin
                    if (!match)
                        good_cnt <= '0;
                    else begin
                        good_cnt <= good_cnt + 1'b1;
                        if (good_cnt == LOCK_LAST) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        state     <= ACQUIRE;
                        locked    <= 1'b0;
                        good_cnt  <= '0;
                        err_pulse <= 1'b1;
                        err_count <= &err_count ? err_count : err_count + 1'b1;
                        last_bad  <= count;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_8bit_monitor.sv
// tb_counter_8bit_monitor: directed and random stimulus checked against a behavioural monitor model
module tb_counter_8bit_monitor;
    localparam int LOCK = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        count_enb = 1'b0;
    logic [7:0]  count = 8'd0;
    logic        locked, err_pulse, wrap_pulse;
    logic [15:0] err_count, wrap_count;
    logic [7:0]  last_bad;
    logic        s_locked, s_err_pulse, s_wrap_pulse;
    logic [1:0]  s_err_count, s_wrap_count;
    logic [7:0]  s_last_bad;

    int checks = 0;
    int errors = 0;

    bit         m_started, m_locked, m_enb, e_err, e_wrap;
    int         m_good, m_errs, m_wraps;
    logic [7:0] m_prev, m_bad, ctr;
    int         s_pulses;

    counter_8bit_monitor dut (
        .clk(clk), .reset(reset), .count_enb(count_enb), .count(count),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .wrap_pulse(wrap_pulse), .wrap_count(wrap_count), .last_bad(last_bad)
    );

    counter_8bit_monitor #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .count_enb(count_enb), .count(count),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
        .wrap_pulse(s_wrap_pulse), .wrap_count(s_wrap_count), .last_bad(s_last_bad)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v, input int w);
        return v > (1 << w) - 1 ? (1 << w) - 1 : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model(input logic r, input logic en, input logic [7:0] c);
        logic [7:0] e;
        e_err  = 0;
        e_wrap = 0;
        if (!r) begin
            {m_started, m_locked, m_enb} = '0;
            {m_good, m_errs, m_wraps} = '0;
            m_prev = 0;
            m_bad  = 0;
            return;
        end
        e = m_enb ? m_prev + 8'd1 : m_prev;
        if (!m_started) begin
            m_started = 1;
            m_good    = 0;
        end else if (!m_locked) begin
            m_good   = (c == e) ? m_good + 1 : 0;
            m_locked = m_good == LOCK;
        end else if (c != e) begin
            m_errs++;
            m_bad    = c;
            m_locked = 0;
            m_good   = 0;
            e_err    = 1;
        end else if (m_enb && m_prev == 8'hFF && c == 8'h00) begin
            m_wraps++;
            e_wrap = 1;
        end
        m_prev = c;
        m_enb  = en;
    endtask

    task automatic step(input logic r, input logic en, input logic [7:0] c);
        reset = r;
        count_enb = en;
        count = c;
        @(posedge clk);
        model(r, en, c);
        #1;
        check("locked", 32'(locked), 32'(m_locked));
        check("err_pulse", 32'(err_pulse), 32'(e_err));
        check("wrap_pulse", 32'(wrap_pulse), 32'(e_wrap));
        check("err_count", 32'(err_count), 32'(sat(m_errs, 16)));
        check("wrap_count", 32'(wrap_count), 32'(sat(m_wraps, 16)));
        check("last_bad", 32'(last_bad), 32'(m_bad));
        check("s_err_pulse", 32'(s_err_pulse), 32'(e_err));
        check("s_err_count", 32'(s_err_count), 32'(sat(m_errs, 2)));
        check("s_wrap_count", 32'(s_wrap_count), 32'(sat(m_wraps, 2)));
        if (s_err_pulse) s_pulses++;
    endtask

    task automatic run(input int n, input bit rand_en);
        logic en;
        for (int i = 0; i < n; i++) begin
            en = rand_en ? 1'($urandom) : 1'b1;
            step(1, en, ctr);
            ctr = ctr + {7'd0, en};
        end
    endtask

    initial begin
        logic       en;
        logic [7:0] c, g;
        step(0, 0, 8'h00);
        step(0, 1, 8'h5A);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_last_bad", 32'(last_bad), 32'd0);
        ctr = 0;
        run(4, 0);
        check("not_yet_locked", 32'(locked), 32'd0);
        run(1, 0);
        check("locked_after_5", 32'(locked), 32'd1);
        run(256, 0);
        check("wrap_count_1", 32'(wrap_count), 32'd1);
        check("no_errors", 32'(err_count), 32'd0);

        while (ctr != 8'h37) run(1, 0);
        step(1, 0, ctr);
        for (int i = 0; i < 8; i++) step(1, 0, ctr);
        check("hold_locked", 32'(locked), 32'd1);
        check("hold_no_err", 32'(err_count), 32'd0);
        run(1, 0);

        while (ctr != 8'h10) run(1, 0);
        run(1, 0);
        step(1, 1, 8'h20);
        check("inject_pulse", 32'(err_pulse), 32'd1);
        check("inject_last_bad", 32'(last_bad), 32'h20);
        check("inject_unlocked", 32'(locked), 32'd0);
        check("inject_err_count", 32'(err_count), 32'd1);
        ctr = 8'h21;
        run(1, 0);
        check("pulse_one_cycle", 32'(err_pulse), 32'd0);
        run(3, 0);
        check("relocked", 32'(locked), 32'd1);

        while (ctr != 8'h40) run(1, 0);
        step(1, 0, 8'h40);
        step(1, 0, 8'h41);
        check("hold_step_pulse", 32'(err_pulse), 32'd1);
        check("hold_step_last_bad", 32'(last_bad), 32'h41);
        ctr = 8'h41;
        run(6, 1);

        step(0, 1'($urandom), 8'($urandom));
        check("midreset_err_count", 32'(err_count), 32'd0);
        check("midreset_err_pulse", 32'(err_pulse), 32'd0);
        ctr = 8'($urandom);
        run(5, 0);
        check("midreset_relock", 32'(locked), 32'd1);

        s_pulses = 0;
        for (int k = 0; k < 5; k++) begin
            run(6, 0);
            g = ctr + 8'h55;
            step(1, 1, g);
            ctr = g + 8'd1;
        end
        check("sat_pulses", 32'(s_pulses), 32'd5);
        check("sat_small_count", 32'(s_err_count), 32'd3);
        check("sat_full_count", 32'(err_count), 32'd5);

        for (int i = 0; i < 1500; i++) begin
            en = 1'($urandom);
            c = ($urandom_range(0, 19) == 0) ? 8'($urandom) : ctr;
            step(($urandom_range(0, 99) != 0), en, c);
            ctr = c + {7'd0, en};
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
